irq_ctrl_n: RTL and testbench

IRQ_CTRL_N -- requirements
Module: irq_ctrl_n

---
 rtl/irq_ctrl_n.sv | 129 ++++++++++++
 tb/tb_irq_ctrl_n.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_n.sv
// rtl/irq_ctrl_n.sv - interrupt controller: pending/enable/claim regs, one-at-a-time delivery FSM
// Optional IRQ_EDGE_EN adds the MODE register and per-source edge detection.
module irq_ctrl_n #(
  parameter int N_SRC     = 8,
  parameter int TIMER_SRC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  output logic             interrupt,
  output logic             int_istimer,
  input  logic             int_reply,
  input  logic [2:0]       a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [N_SRC-1:0] pending, enable, set_vec, clr_vec, ack_vec, pend_en;
  logic [N_SRC-1:0] mode_q;
  logic [4:0]       id, low_id;
  logic             claim_valid;
  logic             ack;
  logic [31:0]      unused_d;

  assign unused_d = d;
  assign pend_en  = pending & enable;
  assign ack      = (state == S_ASSERT) && int_reply;

`ifdef IRQ_EDGE_EN
  logic [N_SRC-1:0] mode, hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= '0;
      hist <= '0;
    end else begin
      hist <= irq_src;
      if (we && a == 3'd3) mode <= d[N_SRC-1:0];
    end
  end

  // Edge-mode sources set only on a 0->1 transition of the raw input.
  assign set_vec = (irq_src & ~mode) | (irq_src & mode & ~hist);
  assign mode_q  = mode;
`else
  assign set_vec = irq_src;
  assign mode_q  = '0;
`endif

  always_comb begin
    ack_vec = '0;
    low_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      ack_vec[i] = ack && (id == i[4:0]);
      if (pend_en[i]) low_id = i[4:0];
    end
  end

  assign clr_vec = ((we && a == 3'd0) ? d[N_SRC-1:0] : '0) | ack_vec;

  // Set wins over a simultaneous W1C or acknowledge on the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (we && a == 3'd1) enable <= d[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id          <= '0;
      claim_valid <= 1'b0;
    end else if (state == S_IDLE && pend_en != '0) begin
      id          <= low_id;
      claim_valid <= 1'b1;
    end else if (ack) begin
      claim_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (pend_en != '0) state_next = S_ASSERT;
      S_ASSERT: if (int_reply)     state_next = S_GAP;
      S_GAP:                       state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  // Once asserted, the request holds until acknowledged regardless of software changes.
  always_comb begin
    interrupt   = 1'b0;
    int_istimer = 1'b0;
    if (state == S_ASSERT) begin
      interrupt   = 1'b1;
      int_istimer = (id == TIMER_SRC[4:0]);
    end
  end

  always_comb begin
    spo = '0;
    case (a)
      3'd0:    spo = 32'(pending);
      3'd1:    spo = 32'(enable);
      3'd2:    spo = {claim_valid, 26'd0, id};
      3'd3:    spo = 32'(mode_q);
      3'd4:    spo = 32'(irq_src);
      default: spo = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl_n.sv
// tb/tb_irq_ctrl_n.sv - directed self-checking bench for irq_ctrl_n
module tb_irq_ctrl_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        interrupt, int_istimer, int_reply;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  int          checks = 0;
  int          errors = 0;
  int          deliveries;

  irq_ctrl_n #(.N_SRC(8), .TIMER_SRC(0)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .interrupt(interrupt),
    .int_istimer(int_istimer), .int_reply(int_reply), .a(a), .d(d),
    .we(we), .spo(spo)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    a = addr;
    #1;
    chk(tag, spo, exp);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    a = addr; d = data; we = 1'b1;
    tick();
    we = 1'b0; d = '0;
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; int_reply = 1'b0; a = '0; d = '0; we = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
    chk("rst_istimer", {31'd0, int_istimer}, 32'd0);
    rd(3'd0, 32'd0, "rst_pending");
    rd(3'd1, 32'd0, "rst_enable");
    rd(3'd2, 32'd0, "rst_claim");
    rd(3'd3, 32'd0, "rst_mode");

    // single pulse on source 2
    wr(3'd1, 32'h05);
    rd(3'd1, 32'h05, "enable_rd");
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    rd(3'd0, 32'h04, "p2_pending");
    chk("p2_int_before", {31'd0, interrupt}, 32'd0);
    tick();
    chk("p2_int", {31'd0, interrupt}, 32'd1);
    chk("p2_istimer", {31'd0, int_istimer}, 32'd0);
    rd(3'd2, 32'h80000002, "p2_claim");
    int_reply = 1'b1;
    tick();
    int_reply = 1'b0;
    chk("p2_gap_int", {31'd0, interrupt}, 32'd0);
    rd(3'd0, 32'h00, "p2_pending_clr");
    rd(3'd2, 32'h00000002, "p2_claim_invalid");
    tick();
    chk("p2_idle_int", {31'd0, interrupt}, 32'd0);
    tick();
    chk("p2_idle2_int", {31'd0, interrupt}, 32'd0);

    // simultaneous timer source 0 and source 3
    wr(3'd1, 32'hFF);
    irq_src = 8'h09;
    tick();
    irq_src = 8'h00;
    tick();
    chk("t0_int", {31'd0, interrupt}, 32'd1);
    chk("t0_istimer", {31'd0, int_istimer}, 32'd1);
    rd(3'd2, 32'h80000000, "t0_claim");
    int_reply = 1'b1;
    tick();
    int_reply = 1'b0;
    chk("t0_gap_int", {31'd0, interrupt}, 32'd0);
    rd(3'd0, 32'h08, "t0_pending_left");
    tick();
    chk("t3_idle_int", {31'd0, interrupt}, 32'd0);
    tick();
    chk("t3_int", {31'd0, interrupt}, 32'd1);
    chk("t3_istimer", {31'd0, int_istimer}, 32'd0);
    rd(3'd2, 32'h80000003, "t3_claim");
    int_reply = 1'b1;
    tick();
    int_reply = 1'b0;
    tick();
    rd(3'd0, 32'h00, "t3_pending_clr");

    // pending without enable; stray reply while idle
    wr(3'd1, 32'h00);
    irq_src = 8'h10;
    tick();
    irq_src = 8'h00;
    rd(3'd0, 32'h10, "noen_pending");
    rd(3'd4, 32'h00, "raw_rd");
    tick();
    chk("noen_int", {31'd0, interrupt}, 32'd0);
    int_reply = 1'b1;
    tick();
    int_reply = 1'b0;
    rd(3'd0, 32'h10, "idle_reply_ignored");
    wr(3'd0, 32'h10);
    rd(3'd0, 32'h00, "w1c_clear");

    // W1C racing a new set on source 2
    a = 3'd0; d = 32'h04; we = 1'b1; irq_src = 8'h04;
    tick();
    we = 1'b0; irq_src = 8'h00;
    rd(3'd0, 32'h04, "set_beats_clr");
    wr(3'd0, 32'h04);
    rd(3'd0, 32'h00, "set_beats_clr_cleanup");

    // software disables and clears during ASSERT
    wr(3'd1, 32'h02);
    irq_src = 8'h02;
    tick();
    irq_src = 8'h00;
    tick();
    chk("dis_int", {31'd0, interrupt}, 32'd1);
    rd(3'd2, 32'h80000001, "dis_claim");
    wr(3'd1, 32'h00);
    chk("dis_int_hold1", {31'd0, interrupt}, 32'd1);
    wr(3'd0, 32'h02);
    chk("dis_int_hold2", {31'd0, interrupt}, 32'd1);
    rd(3'd0, 32'h00, "dis_pending");
    tick();
    chk("dis_int_hold3", {31'd0, interrupt}, 32'd1);
    wr(3'd6, 32'hFFFFFFFF);
    rd(3'd6, 32'h00, "a6_read");
    rd(3'd1, 32'h00, "a6_no_side_effect");
    int_reply = 1'b1;
    tick();
    int_reply = 1'b0;
    chk("dis_after_reply", {31'd0, interrupt}, 32'd0);
    tick();

    // reset during ASSERT with write and reply held
    wr(3'd1, 32'hFF);
    irq_src = 8'h20;
    tick();
    irq_src = 8'h40;
    tick();
    irq_src = 8'h00;
    chk("rs_int", {31'd0, interrupt}, 32'd1);
    rd(3'd2, 32'h80000005, "rs_claim");
    rst = 1'b1; we = 1'b1; a = 3'd1; d = 32'hFF; int_reply = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0; d = '0; int_reply = 1'b0;
    chk("rs_int_low", {31'd0, interrupt}, 32'd0);
    chk("rs_istimer_low", {31'd0, int_istimer}, 32'd0);
    rd(3'd0, 32'h00, "rs_pending");
    rd(3'd1, 32'h00, "rs_enable");
    rd(3'd2, 32'h00, "rs_claim_clr");
    tick();
    chk("rs_int_stays_low", {31'd0, interrupt}, 32'd0);

`ifdef IRQ_EDGE_EN
    wr(3'd3, 32'h02);
    rd(3'd3, 32'h02, "mode_rd");
    wr(3'd1, 32'h12);
    irq_src = 8'h02;
    deliveries = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (interrupt) deliveries++;
      int_reply = interrupt;
    end
    chk("edge_one_delivery", deliveries, 32'd1);
    irq_src = 8'h10;
    deliveries = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (interrupt) deliveries++;
      int_reply = interrupt;
    end
    irq_src = 8'h00;
    tick();
    int_reply = 1'b0;
    chk("level_redelivery", deliveries, 32'd7);
`else
    wr(3'd3, 32'h02);
    rd(3'd3, 32'h00, "mode_ignored");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
